// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer that splits a wide vector load/store into word beats
// on the scalar data-memory port and stalls the pipeline while it runs.
module vector_mem_sequencer #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         VecLoadM,
  input  logic         VecStoreM,
  input  logic [N-1:0] AddrM,
  input  logic [V-1:0] WriteDataVM,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] mem_addr,
  output logic         mem_re,
  output logic         mem_we,
  output logic [N-1:0] mem_wdata,
  output logic [V-1:0] ReadDataVM,
  output logic         StallVM,
  output logic         VecDoneM
);

  localparam int BEATS = V / N;
  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STORE, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic [KW-1:0] k_prev;
  logic [N-1:0]  base;
  logic [V-1:0]  data;
  logic [N-1:0]  beat_addr;
  logic          request;

  assign request   = VecLoadM | VecStoreM;
  assign k_prev    = k - 1'b1;
  assign beat_addr = base + (N'(k) << 2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      k          <= '0;
      base       <= '0;
      data       <= '0;
      ReadDataVM <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (request) begin
            base <= AddrM;
            data <= WriteDataVM;
            k    <= '0;
          end
        end
        LOAD: begin
          k <= k + 1'b1;
          // Read data lags the address by one cycle, so this cycle's word
          // belongs to the beat issued last cycle.
          if (k != '0) ReadDataVM[k_prev*N +: N] <= mem_rdata;
        end
        DRAIN:   ReadDataVM[(BEATS-1)*N +: N] <= mem_rdata;
        STORE:   k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    StallVM   = 1'b0;
    VecDoneM  = 1'b0;
    case (state)
      IDLE: begin
        // No stall request while reset is held: no transfer can start then.
        StallVM = request & rst;
        if (request) state_nxt = VecLoadM ? LOAD : STORE;
      end
      LOAD: begin
        mem_re   = 1'b1;
        mem_addr = beat_addr;
        StallVM  = 1'b1;
        if (k == K_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        StallVM   = 1'b1;
        state_nxt = DONE;
      end
      STORE: begin
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = data[k*N +: N];
        StallVM   = 1'b1;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        // The finished instruction is still on the inputs; never restart here.
        VecDoneM  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
